// File: rtl/booth_pkg.sv
// Shared Booth radix-4 encoding constants and the group-to-code mapping used
// by the partial-product array and its rows.
package booth_pkg;

    localparam logic [2:0] ENC_ZERO = 3'b000;
    localparam logic [2:0] ENC_P1   = 3'b001;
    localparam logic [2:0] ENC_P2   = 3'b010;
    localparam logic [2:0] ENC_M1   = 3'b101;
    localparam logic [2:0] ENC_M2   = 3'b110;

    // grp = {b[2i+1], b[2i], b[2i-1]}; 000/111 both map to plain zero so
    // a negated zero never reaches the rows.
    function automatic logic [2:0] booth_enc(input logic [2:0] grp);
        logic [2:0] code;
        case (grp)
            3'b001, 3'b010: code = ENC_P1;
            3'b011:         code = ENC_P2;
            3'b100:         code = ENC_M2;
            3'b101, 3'b110: code = ENC_M1;
            default:        code = ENC_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: selects 0 / a / 2a, applies full two's
// complement negation and shifts the result to the weight of its group.
module booth_pp_row
    import booth_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ROW    = 0
) (
    input  logic [2:0]          i_enc,
    input  logic [2*DATA_W-1:0] i_a_ext,
    output logic [2*DATA_W-1:0] o_pp
);

    localparam int PP_W = 2 * DATA_W;
    localparam logic [PP_W-1:0] ONE = {{(PP_W-1){1'b0}}, 1'b1};

    logic [PP_W-1:0] w_mag;
    logic [PP_W-1:0] w_val;

    // Magnitude select, negation and weight shift, all truncated to 2W bits.
    always_comb begin
        w_mag = '0;
        w_val = '0;
        case (i_enc)
            ENC_P1, ENC_M1: w_mag = i_a_ext;
            ENC_P2, ENC_M2: w_mag = {i_a_ext[PP_W-2:0], 1'b0};
            default:        w_mag = '0;
        endcase
        if (i_enc[2]) begin
            w_val = ~w_mag + ONE;
        end else begin
            w_val = w_mag;
        end
        o_pp = w_val << (2 * ROW);
    end

endmodule

// File: rtl/booth_pp_array.sv
// Two-stage pipelined radix-4 Booth partial-product generator with
// valid/ready handshake on both sides; signed or unsigned per transaction.
module booth_pp_array
    import booth_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_signed,
    input  logic [DATA_W-1:0]                   in_a,
    input  logic [DATA_W-1:0]                   in_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [(DATA_W/2+1)*2*DATA_W-1:0]    out_pp,
    output logic [(DATA_W/2+1)*3-1:0]           out_enc
);

    localparam int N_PP = DATA_W / 2 + 1;
    localparam int PP_W = 2 * DATA_W;

    logic                   w_adv;
    logic                   w_in_ready;
    logic [DATA_W+2:0]      w_b_pad;
    logic [PP_W-1:0]        w_a_ext;
    logic [N_PP*3-1:0]      w_enc;
    logic [N_PP*PP_W-1:0]   w_pp;

    logic                   r_s1_valid;
    logic [PP_W-1:0]        r_s1_a_ext;
    logic [N_PP*3-1:0]      r_s1_enc;
    logic                   r_out_valid;
    logic [N_PP*PP_W-1:0]   r_out_pp;
    logic [N_PP*3-1:0]      r_out_enc;

    // Stage 2 may load whenever its holder is empty or being drained; stage 1
    // additionally accepts when it is itself empty.
    always_comb begin
        w_adv      = !r_out_valid || out_ready;
        w_in_ready = !r_s1_valid || w_adv;
    end

    // Operand extension and Booth recoding; the pad bit below b[0] is b[-1]=0.
    always_comb begin
        w_b_pad = {{2{in_signed & in_b[DATA_W-1]}}, in_b, 1'b0};
        w_a_ext = {{DATA_W{in_signed & in_a[DATA_W-1]}}, in_a};
        w_enc   = '0;
        for (int i = 0; i < N_PP; i++) begin
            w_enc[i*3 +: 3] = booth_enc(w_b_pad[2*i +: 3]);
        end
    end

    // Stage 1: extended multiplicand and Booth codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a_ext <= '0;
            r_s1_enc   <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a_ext <= w_a_ext;
                r_s1_enc   <= w_enc;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_PP; g++) begin : g_row
            booth_pp_row #(
                .DATA_W (DATA_W),
                .ROW    (g)
            ) u_row (
                .i_enc   (r_s1_enc[g*3 +: 3]),
                .i_a_ext (r_s1_a_ext),
                .o_pp    (w_pp[g*PP_W +: PP_W])
            );
        end
    endgenerate

    // Stage 2: finished partial products held until downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pp    <= '0;
            r_out_enc   <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_pp  <= w_pp;
                r_out_enc <= r_s1_enc;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_pp    = r_out_pp;
    assign out_enc   = r_out_enc;

endmodule

// File: tb/tb_booth_pp_array.sv
// Scoreboard bench for booth_pp_array: directed vectors, stall/reset
// behaviour at W=16 and a sum-invariant sweep at W=4, 8 and 32.
module tb_booth_pp_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0]  in_a, in_b;
    logic [287:0] out_pp;
    logic [26:0]  out_enc;

    logic         v4_valid, v4_ready, v4_signed, v4_ovalid;
    logic [3:0]   v4_a, v4_b;
    logic [23:0]  v4_pp;
    logic [8:0]   v4_enc;

    logic         v8_valid, v8_ready, v8_signed, v8_ovalid;
    logic [7:0]   v8_a, v8_b;
    logic [79:0]  v8_pp;
    logic [14:0]  v8_enc;

    logic         v32_valid, v32_ready, v32_signed, v32_ovalid;
    logic [31:0]  v32_a, v32_b;
    logic [1087:0] v32_pp;
    logic [50:0]  v32_enc;

    logic         sweep_rdy;

    booth_pp_array #(.DATA_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_pp(out_pp), .out_enc(out_enc));

    booth_pp_array #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_valid), .in_ready(v4_ready),
        .in_signed(v4_signed), .in_a(v4_a), .in_b(v4_b), .out_valid(v4_ovalid),
        .out_ready(sweep_rdy), .out_pp(v4_pp), .out_enc(v4_enc));

    booth_pp_array #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_valid), .in_ready(v8_ready),
        .in_signed(v8_signed), .in_a(v8_a), .in_b(v8_b), .out_valid(v8_ovalid),
        .out_ready(sweep_rdy), .out_pp(v8_pp), .out_enc(v8_enc));

    booth_pp_array #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32_valid), .in_ready(v32_ready),
        .in_signed(v32_signed), .in_a(v32_a), .in_b(v32_b), .out_valid(v32_ovalid),
        .out_ready(sweep_rdy), .out_pp(v32_pp), .out_enc(v32_enc));

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q16[$];
    logic [63:0] q4[$];
    logic [63:0] q8[$];
    logic [63:0] q32[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask2(input int w);
        if (w >= 32) return {64{1'b1}};
        return (64'd1 << (2 * w)) - 64'd1;
    endfunction

    // Reference product modulo 2^(2W), operands interpreted per signed flag.
    function automatic logic [63:0] exp_prod(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
        logic [63:0] am, ae, be;
        am = (64'd1 << w) - 64'd1;
        ae = a & am;
        be = b & am;
        if (s && ae[w-1]) ae = ae | ~am;
        if (s && be[w-1]) be = be | ~am;
        return (ae * be) & mask2(w);
    endfunction

    function automatic logic [63:0] sum_pp(input logic [1087:0] pp, input int w);
        logic [63:0]   s;
        logic [1087:0] t;
        s = 64'd0;
        for (int i = 0; i < w / 2 + 1; i++) begin
            t = pp >> (i * 2 * w);
            s = s + t[63:0];
        end
        return s & mask2(w);
    endfunction

    // Output side of every scoreboard: pop in order and check the sum invariant.
    always @(negedge clk) begin
        logic [63:0] e;
        if (out_valid && out_ready) begin
            check_val("m16_nonempty", 64'(q16.size() > 0), 64'd1);
            if (q16.size() > 0) begin
                e = q16.pop_front();
                check_val("m16_sum", sum_pp(1088'(out_pp), 16), e);
            end
        end
        if (v4_ovalid && sweep_rdy) begin
            check_val("w4_nonempty", 64'(q4.size() > 0), 64'd1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check_val("w4_sum", sum_pp(1088'(v4_pp), 4), e);
            end
        end
        if (v8_ovalid && sweep_rdy) begin
            check_val("w8_nonempty", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check_val("w8_sum", sum_pp(1088'(v8_pp), 8), e);
            end
        end
        if (v32_ovalid && sweep_rdy) begin
            check_val("w32_nonempty", 64'(q32.size() > 0), 64'd1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                check_val("w32_sum", sum_pp(v32_pp, 32), e);
            end
        end
    end

    // Present one pair to the W=16 instance and hold it until accepted.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
        bit acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check_val("send_accept", 64'(acc), 64'd1);
        if (acc) q16.push_back(exp_prod(64'(a), 64'(b), s, 16));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (q16.size() == 0 && q4.size() == 0 && q8.size() == 0 && q32.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain16", 64'(q16.size()), 64'd0);
        check_val("drain_sweep", 64'(q4.size() + q8.size() + q32.size()), 64'd0);
    endtask

    bit saw_stall;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        v4_valid = 1'b0; v4_signed = 1'b0; v4_a = '0; v4_b = '0;
        v8_valid = 1'b0; v8_signed = 1'b0; v8_a = '0; v8_b = '0;
        v32_valid = 1'b0; v32_signed = 1'b0; v32_a = '0; v32_b = '0;
        sweep_rdy = 1'b1;
        saw_stall = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_pp_zero", 64'(|out_pp), 64'd0);
        check_val("rst_enc", 64'(out_enc), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3 x 5 unsigned, with latency check
        send16(16'd3, 16'd5, 1'b0);
        @(negedge clk);
        check_val("t1_lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_val("t1_lat_valid", 64'(out_valid), 64'd1);
        check_val("t1_enc", 64'(out_enc), 64'd9);
        check_val("t1_pp0", 64'(out_pp[31:0]), 64'h3);
        check_val("t1_pp1", 64'(out_pp[63:32]), 64'hC);
        check_val("t1_rest", 64'((out_pp >> 64) == 288'd0), 64'd1);
        @(posedge clk);
        #1;

        // -1 x -1 signed
        send16(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) @(negedge clk);
        check_val("t2_valid", 64'(out_valid), 64'd1);
        check_val("t2_enc", 64'(out_enc), 64'd5);
        check_val("t2_pp0", 64'(out_pp[31:0]), 64'h1);
        check_val("t2_rest", 64'((out_pp >> 32) == 288'd0), 64'd1);
        @(posedge clk);
        #1;

        // 0xFFFF x 0xFFFF unsigned
        send16(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (2) @(negedge clk);
        check_val("t3_valid", 64'(out_valid), 64'd1);
        check_val("t3_enc", 64'(out_enc), 64'h1000005);
        check_val("t3_pp0", 64'(out_pp[31:0]), 64'hFFFF0001);
        check_val("t3_pp8", 64'(out_pp[287:256]), 64'hFFFF0000);
        check_val("t3_mid", 64'(out_pp[255:32] == 224'd0), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream of 8 with out_ready low for cycles 3..6
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = !(c >= 3 && c <= 6);
                end
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(negedge clk);
                    if (!in_ready) saw_stall = 1'b1;
                end
            end
        join
        out_ready = 1'b1;
        check_val("stream_stall_seen", 64'(saw_stall), 64'd1);
        wait_drain(30);

        // Reset with both stages full
        out_ready = 1'b0;
        send16(16'h1234, 16'h8765, 1'b1);
        send16(16'h00FF, 16'h7F01, 1'b0);
        @(negedge clk);
        check_val("full_out_valid", 64'(out_valid), 64'd1);
        check_val("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_pp_zero", 64'(|out_pp), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        q16.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send16(16'h0007, 16'hFFF9, 1'b1);
        @(negedge clk);
        check_val("post_rst_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_val("post_rst_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain(10);

        // Sweep: exhaustive W=4, random W=8 / W=32, both modes
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    v4_valid = 1'b1;  v4_signed = 1'(s);  v4_a = 4'(a); v4_b = 4'(b);
                    v8_valid = 1'b1;  v8_signed = 1'(s);
                    v8_a = 8'($urandom); v8_b = 8'($urandom);
                    v32_valid = 1'b1; v32_signed = 1'(s);
                    v32_a = $urandom; v32_b = $urandom;
                    q4.push_back(exp_prod(64'(v4_a), 64'(v4_b), v4_signed, 4));
                    q8.push_back(exp_prod(64'(v8_a), 64'(v8_b), v8_signed, 8));
                    q32.push_back(exp_prod(64'(v32_a), 64'(v32_b), v32_signed, 32));
                    @(posedge clk);
                    #1;
                end
            end
        end
        v4_valid = 1'b0;
        v8_valid = 1'b0;
        v32_valid = 1'b0;
        wait_drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_pp_array.md
# booth_pp_array

Pipelined, parametrised radix-4 Booth partial-product generator feeding the Wallace-tree reduction stage of the multiplier. It accepts one multiplicand/multiplier pair per cycle under a valid/ready handshake and supports signed or unsigned operands per transaction. It emits all W/2+1 partial products at once, fully negated, sign-extended and pre-shifted to their weight. Downstream reduction only sums them, modulo 2^(2W).

## Interface
- DATA_W, 16, operand width; even, ≥4.
- N_PP, DATA_W/2+1, partial-product count; derived, not overridable.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_a  in  DATA_W  multiplicand.
- in_b  in  DATA_W  multiplier; Booth-recoded.
- out_valid  out  1  partial products present.
- out_ready  in  1  downstream accepts.
- out_pp  out  N_PP*2*DATA_W  PP i occupies bits [i*2W +: 2W].
- out_enc  out  N_PP*3  Booth codes for debug, 3 bits per group.

## Operation
- Handshake: a transfer occurs when valid && ready. in_valid/in_a/in_b/in_signed are stable only when in_valid=1. out_* hold stable while out_valid && !out_ready.
- Multiplier extension: b_ext is W+2 bits. It is sign-extended when in_signed=1 and zero-extended when in_signed=0. b[-1]=0.
- Group i (0..N_PP-1) = (b_ext[2i+1], b_ext[2i], b_ext[2i-1]). Codes, with enc[2] = negate and enc[1:0] = 00 zero / 01 ×1 / 10 ×2:
  - 000 and 111 → 000.
  - 001 and 010 → 001.
  - 011 → 010.
  - 100 → 110.
  - 101 and 110 → 101.
- Negative zero is never encoded. In signed mode the top group is always 000.
- Multiplicand is extended to 2W bits: sign-extended when signed, zero-extended otherwise.
- PP_i = (enc[2] ? −M : M), where M = 0, a_ext or a_ext<<1 per enc[1:0], then shifted left by 2i. All arithmetic is truncated to 2W bits. Negation is full two's complement (invert + 1), done inside the block; no correction bits are passed on.
- Invariant: the sum over i of PP_i mod 2^(2W) equals a×b, interpreted per in_signed.

## Timing
- Stage 1 register: a_ext, Booth codes, valid.
- Stage 2 register: out_pp, out_enc, out_valid.
- Latency: 2 cycles from accepted input to out_valid, when there is no stall.
- Throughput: 1 transaction per cycle.
- Stall rules:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances under the same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready). in_ready is combinational from out_ready.
- With both stages full and out_ready=0, in_ready=0 and no data is lost or duplicated.
- When out_ready=1 and stage 1 is full, an input transfer and an output transfer in the same cycle are both honoured.
- Reset: asserting rst_n at any time clears s1_valid and out_valid to 0, and out_pp and out_enc to 0. In-flight data is discarded. in_ready is 1 during and after reset.

## Structure
- booth_pkg holds:
  - Encoding constants: ENC_ZERO=3'b000, ENC_P1=3'b001, ENC_P2=3'b010, ENC_M1=3'b101, ENC_M2=3'b110.
  - The function mapping a 3-bit group to its code.
- Sub-module booth_pp_row (combinational): takes one code, a_ext and the row index, and produces one shifted 2W-bit PP. It is instantiated N_PP times with a generate loop between the two stages.
- Top-level holds the pipeline registers and the handshake.

## Test plan
- W=16, unsigned, a=3, b=5:
  - Codes g0=001, g1=001, rest 000.
  - PP0=0x00000003, PP1=0x0000000C, rest 0.
  - out_valid two cycles after acceptance.
- W=16, signed, a=0xFFFF, b=0xFFFF:
  - g0=101, so PP0=0x00000001.
  - All other groups 000. Sum=1.
- W=16, unsigned, a=b=0xFFFF:
  - PP0=0xFFFF0001, PP8=0xFFFF0000, rest 0.
  - Sum mod 2^32 = 0xFFFE0001.
- Back-to-back stream of 8 pairs with out_ready=0 for cycles 3–6:
  - in_ready drops once both stages are full.
  - Outputs appear in order with no loss or duplication.
  - Randomised pairs are checked against the sum invariant.
- Reset mid-stream: assert rst_n=0 with both stages full.
  - out_valid=0 and out_pp=0 immediately, asynchronously.
  - After release, the first accepted pair emerges 2 cycles later.
- Parameter sweep W=4, 8, 32: exhaustive for W=4 and random for larger W, in both modes, against the sum invariant.
